systolic_feeder: RTL and testbench
==================================

SYSTOLIC_FEEDER -- requirements
Module: systolic_feeder

Interface
REQ-001 SHALL have parameter N, default 4: systolic array edge size, giving N A-lanes and N B-lanes, legal range 1..16.
REQ-002 SHALL have parameter CNT_W, default 16: width of the beat counter.
REQ-003 SHALL have port clk, input, 1 bit: single clock, all logic on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: synchronous reset, active-low.
REQ-005 SHALL have port in_valid, input, 1 bit: upstream beat valid.
REQ-006 SHALL have port in_ready, output, 1 bit: feeder accepts a beat.
REQ-007 SHALL have port in_a, input, N*8 bits: FP8 E4M3 A column, one byte per row; lane i = bits [8i+7:8i].
REQ-008 SHALL have port in_b, input, N*8 bits: FP8 E4M3 B row, one byte per column.
REQ-009 SHALL have port in_last, input, 1 bit: beat is the final k of the current dot product.
REQ-010 SHALL have port a_out, output, N*8 bits: skewed A lanes to the array's west edge.
REQ-011 SHALL have port b_out, output, N*8 bits: skewed B lanes to the array's north edge.
REQ-012 SHALL have port first_out, output, N bits: accumulator-clear marker, skewed with the A lanes.
REQ-013 SHALL have port busy, output, 1 bit: state is not IDLE.
REQ-014 SHALL have port tile_done, output, 1 bit: one-cycle pulse when the last beat exits lane N-1.
REQ-015 SHALL have port beat_count, output, CNT_W bits: beats accepted in the current tile.

Function
REQ-016 SHALL accept a beat when in_valid && in_ready are both high on a rising edge ("handshake").
REQ-017 SHALL implement states IDLE, STREAM and FLUSH.
REQ-018 SHALL drive in_ready = 1 in IDLE and STREAM, and 0 in FLUSH.
REQ-019 SHALL, for a beat accepted at cycle t, present lane i of in_a on a_out lane i and lane i of in_b on b_out lane i at cycle t+1+i (one input register plus an i-stage delay line per lane).
REQ-020 SHALL inject 0x00 into both lane entries for every cycle without a handshake; an FP8 zero contributes a zero product.
REQ-021 SHALL mark the first beat of each tile (first handshake in IDLE) and propagate the mark with the A skew, so first_out[i] is high exactly when that beat sits on a_out lane i.
REQ-022 SHALL keep first_out low for every other beat and for injected zeros.
REQ-023 SHALL transition IDLE->STREAM on a handshake with in_last=0.
REQ-024 SHALL transition IDLE->FLUSH on a handshake with in_last=1 (single-beat tile).
REQ-025 SHALL transition STREAM->FLUSH on a handshake with in_last=1; STREAM persists through bubbles.
REQ-026 SHALL load a flush counter with N-1 on entry to FLUSH, decrement it each FLUSH cycle, assert tile_done and return to IDLE in the cycle the counter is 0.
REQ-027 SHALL therefore make tile_done occur at cycle t_L+N, where t_L is the cycle of the last handshake; for N=1 this is the cycle after t_L.
REQ-028 SHALL make beat_count = 1 after the first handshake of a tile and increment it on each further handshake.
REQ-029 SHALL hold beat_count through FLUSH, clear it in the tile_done cycle, and saturate it at all-ones without wrapping.
REQ-030 SHALL keep the pipeline advancing every cycle; there is no output back-pressure, and delay lines always shift.
REQ-031 SHALL ignore in_a, in_b and in_last when no handshake occurs.

Reset
REQ-032 SHALL, while rst_n=0 at a rising edge, force state IDLE, in_ready=0 during that cycle, and set all delay-line stages, a_out, b_out and first_out to 0, busy=0, tile_done=0, beat_count=0 and the flush counter=0.
REQ-033 SHALL, on rst_n low mid-STREAM or mid-FLUSH, abandon the in-flight tile with no tile_done and flush in-flight data to zeros.
REQ-034 SHALL drive in_ready=1 in the first cycle after rst_n returns high.

Verification
REQ-035 SHALL pass: N=4, reset then 3 beats, A lanes = 0x38+k, in_last on the third beat -> a_out lane 3 shows 0x38,0x39,0x3A at cycles t0+4..t0+6; first_out[3] high only at t0+4; tile_done at t0+6; beat_count=3 until then.
REQ-036 SHALL pass: single-beat tile with in_last=1 -> IDLE->FLUSH directly, in_ready low for cycles t0+1..t0+4, tile_done at t0+4, first_out[i] at t0+1+i.
REQ-037 SHALL pass: in_valid low for 2 cycles mid-tile -> 0x00 appears on all lanes in the skewed slots, state stays STREAM, beat_count is unchanged across the gap.
REQ-038 SHALL pass: in_valid held high through FLUSH -> no beat accepted and beat_count is unchanged; the next tile starts the cycle after tile_done with first_out re-marked.
REQ-039 SHALL pass: rst_n pulsed low during FLUSH -> no tile_done, all outputs 0 the next cycle, in_ready=1 after release.
REQ-040 SHALL pass: CNT_W=4 with 20 beats -> beat_count saturates at 15, and tile_done is still correct.

Source files
------------

// File: rtl/systolic_feeder.sv
// systolic_feeder: skews FP8 A/B beats into staggered lanes for an NxN systolic array edge,
// marking the first beat of each tile and pulsing tile_done once the last beat leaves lane N-1.
module systolic_feeder #(
  parameter int N = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N*8-1:0]   in_a,
  input  logic [N*8-1:0]   in_b,
  input  logic             in_last,
  output logic [N*8-1:0]   a_out,
  output logic [N*8-1:0]   b_out,
  output logic [N-1:0]     first_out,
  output logic             busy,
  output logic             tile_done,
  output logic [CNT_W-1:0] beat_count
);
  localparam int FW = N > 1 ? $clog2(N) : 1;
  typedef enum logic [1:0] {IDLE, STREAM, FLUSH} state_t;
  state_t state, state_nx;
  logic [FW-1:0] fcnt;
  logic hs, first_in;
  assign in_ready = rst_n && state != FLUSH;
  assign hs = in_valid && in_ready;
  assign first_in = hs && state == IDLE;
  assign busy = state != IDLE;
  assign tile_done = rst_n && state == FLUSH && fcnt == '0;
  always_comb begin
    state_nx = hs ? (in_last ? FLUSH : STREAM) : tile_done ? IDLE : state;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      fcnt <= '0;
      beat_count <= '0;
    end else begin
      state <= state_nx;
      fcnt <= state == FLUSH ? fcnt - 1'b1 : state_nx == FLUSH ? FW'(N - 1) : fcnt;
      beat_count <= tile_done ? '0 : !hs ? beat_count : first_in ? CNT_W'(1) :
                    &beat_count ? beat_count : beat_count + 1'b1;
    end
  end
  // Lane i is an input register followed by i delay stages; idle cycles shift in zeros.
  for (genvar i = 0; i < N; i++) begin : g_lane
    logic [7:0] a_sr [i+1];
    logic [7:0] b_sr [i+1];
    logic       f_sr [i+1];
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        for (int j = 0; j <= i; j++) begin
          a_sr[j] <= '0;
          b_sr[j] <= '0;
          f_sr[j] <= 1'b0;
        end
      end else begin
        a_sr[0] <= hs ? in_a[8*i +: 8] : '0;
        b_sr[0] <= hs ? in_b[8*i +: 8] : '0;
        f_sr[0] <= first_in;
        for (int j = 1; j <= i; j++) begin
          a_sr[j] <= a_sr[j-1];
          b_sr[j] <= b_sr[j-1];
          f_sr[j] <= f_sr[j-1];
        end
      end
    end
    assign a_out[8*i +: 8] = a_sr[i];
    assign b_out[8*i +: 8] = b_sr[i];
    assign first_out[i] = f_sr[i];
  end
endmodule

// File: tb/tb_systolic_feeder.sv
// tb_systolic_feeder: random beats checked every cycle against a tile-level model that
// derives each lane from the beat history (beat at edge k shows on lane i after edge k+i).
module tb_systolic_feeder;
  localparam int N = 4;
  localparam int CNT_W = 4;
  localparam int MAXE = 8192;
  logic clk = 1'b0;
  logic rst_n, in_valid, in_last, in_ready, busy, tile_done;
  logic [N*8-1:0] in_a, in_b, a_out, b_out;
  logic [N-1:0] first_out;
  logic [CNT_W-1:0] beat_count;
  int tests = 0;
  int fails = 0;
  int now = 0;
  int lr = 0;
  int last_edge = -1;
  int cnt = 0;
  bit active = 1'b0;
  logic [N*8-1:0] ha [MAXE];
  logic [N*8-1:0] hb [MAXE];
  bit hf [MAXE];

  systolic_feeder #(.N(N), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_last(in_last), .a_out(a_out), .b_out(b_out),
    .first_out(first_out), .busy(busy), .tile_done(tile_done), .beat_count(beat_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: check the current cycle, then apply the upcoming edge using the (stable) inputs.
  initial forever begin
    bit r, hs, dn, ef;
    int k;
    logic [7:0] ea, eb;
    @(negedge clk);
    if (lr > 0) begin
      chk("in_ready", in_ready, rst_n && last_edge < 0);
      chk("busy", busy, active);
      chk("tile_done", tile_done, rst_n && last_edge >= 0 && now == last_edge + N - 1);
      chk("beat_count", beat_count, cnt);
      for (int i = 0; i < N; i++) begin
        k = now - i;
        if (k < 1 || lr > k) begin
          ea = '0; eb = '0; ef = 1'b0;
        end else begin
          ea = ha[k][8*i +: 8]; eb = hb[k][8*i +: 8]; ef = hf[k];
        end
        chk($sformatf("a_out[%0d]", i), a_out[8*i +: 8], ea);
        chk($sformatf("b_out[%0d]", i), b_out[8*i +: 8], eb);
        chk($sformatf("first_out[%0d]", i), first_out[i], ef);
      end
    end
    r = !rst_n;
    dn = !r && last_edge >= 0 && now == last_edge + N - 1;
    hs = !r && in_valid && last_edge < 0;
    now++;
    if (now >= MAXE) begin
      $display("FAIL history_overflow: got %0d edges, expected < %0d", now, MAXE);
      $fatal(1, "edge budget exceeded");
    end
    if (r || dn) begin
      active = 1'b0; last_edge = -1; cnt = 0;
    end
    if (r) lr = now;
    ha[now] = hs ? in_a : '0;
    hb[now] = hs ? in_b : '0;
    hf[now] = hs && !active;
    if (hs) begin
      cnt = !active ? 1 : cnt == 2**CNT_W - 1 ? cnt : cnt + 1;
      active = 1'b1;
      if (in_last) last_edge = now;
    end
  end

  initial begin
    int c;
    bit seen;
    rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_a = '0; in_b = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_a_out", a_out, 0);
    chk("rst_first", first_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", in_ready, 0);
    chk("rst_count", beat_count, 0);
    // three-beat tile, A lanes 0x38+k
    @(posedge clk); #1;
    rst_n = 1'b1; in_valid = 1'b1; in_a = {N{8'h38}}; in_b = {N{8'h11}};
    @(negedge clk);
    chk("ready_after_rst", in_ready, 1);
    @(posedge clk); #1 in_a = {N{8'h39}};
    @(negedge clk);
    chk("t1_lane0", a_out[7:0], 8'h38);
    chk("t1_first", first_out, 4'b0001);
    chk("t1_count", beat_count, 1);
    @(posedge clk); #1 in_a = {N{8'h3A}}; in_last = 1'b1;
    @(negedge clk);
    chk("t2_first", first_out, 4'b0010);
    @(posedge clk); #1 in_valid = 1'b0; in_last = 1'b0;
    @(negedge clk);
    chk("t3_ready", in_ready, 0);
    chk("t3_count", beat_count, 3);
    @(negedge clk);
    chk("t4_lane3", a_out[31:24], 8'h38);
    chk("t4_first", first_out, 4'b1000);
    chk("t4_done", tile_done, 0);
    @(negedge clk);
    chk("t5_lane3", a_out[31:24], 8'h39);
    chk("t5_first", first_out, 4'b0000);
    @(negedge clk);
    chk("t6_lane3", a_out[31:24], 8'h3A);
    chk("t6_done", tile_done, 1);
    chk("t6_count", beat_count, 3);
    @(negedge clk);
    chk("t7_count", beat_count, 0);
    chk("t7_busy", busy, 0);
    // single-beat tile with in_valid held through the flush
    @(posedge clk); #1 in_valid = 1'b1; in_last = 1'b1; in_a = {N{8'h40}};
    @(posedge clk); #1 in_last = 1'b0; in_a = {N{8'h41}};
    @(negedge clk);
    chk("s1_ready", in_ready, 0);
    chk("s1_first", first_out, 4'b0001);
    repeat (3) @(negedge clk);
    chk("s4_done", tile_done, 1);
    chk("s4_first", first_out, 4'b1000);
    chk("s4_count", beat_count, 1);
    @(negedge clk);
    chk("s5_ready", in_ready, 1);
    @(negedge clk);
    chk("s6_first", first_out, 4'b0001);
    chk("s6_count", beat_count, 1);
    // random traffic: bubbles, short and long tiles, occasional resets
    for (int i = 0; i < 2500; i++) begin
      @(posedge clk); #1;
      rst_n = $urandom_range(0, 199) != 0;
      in_valid = $urandom_range(0, 3) != 0;
      in_last = $urandom_range(0, i < 1200 ? 6 : 30) == 0;
      in_a = $urandom;
      in_b = $urandom;
    end
    // reset during FLUSH abandons the tile
    @(posedge clk); #1 rst_n = 1'b0; in_valid = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1; in_valid = 1'b1; in_last = 1'b1; in_a = $urandom;
    @(posedge clk); #1 in_valid = 1'b0; in_last = 1'b0;
    @(posedge clk); #1 rst_n = 1'b0;
    @(negedge clk);
    chk("rf_done", tile_done, 0);
    chk("rf_ready", in_ready, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rf_a_out", a_out, 0);
    chk("rf_first", first_out, 0);
    chk("rf_busy", busy, 0);
    chk("rf_ready_after", in_ready, 1);
    // 20-beat tile saturates the 4-bit counter
    for (int b = 0; b < 20; b++) begin
      @(posedge clk); #1 in_valid = 1'b1; in_last = b == 19; in_a = $urandom; in_b = $urandom;
    end
    @(posedge clk); #1 in_valid = 1'b0; in_last = 1'b0;
    seen = 1'b0;
    c = 0;
    while (!seen && c < 8) begin
      @(negedge clk);
      if (c == 0) chk("sat_count", beat_count, 15);
      seen = tile_done;
      c++;
    end
    chk("sat_done_seen", seen, 1);
    chk("sat_done_cycle", c, 4);
    repeat (3) @(posedge clk);
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
